goal_scorekeeper: RTL and testbench
===================================

# goal_scorekeeper

Consumes the registered ball position fed back from the ball-motion stage, detects when the ball enters either goal mouth, keeps both players' scores, and drives the `resetGame` pulse that returns the ball (and players) to kick-off. It sits directly downstream of the ball-motion block. Its `resetGame` output closes the loop back into that block and the player-movement blocks. It also supplies score, goal-celebration and game-over status to the VGA/HEX display logic.

## Interface
Parameters:
- `LEFT_GOAL_X`, default 8: ball_x at or below this is inside the left goal line.
- `RIGHT_GOAL_X`, default 152: ball_x + BALL_SIZE at or above this is inside the right goal line.
- `GOAL_Y_MIN`, default 50: lowest ball_y inside either goal mouth (inclusive).
- `GOAL_Y_MAX`, default 70: highest ball_y inside either goal mouth (inclusive).
- `BALL_SIZE`, default 2: ball extent in pixels.
- `HOLD_FRAMES`, default 60: number of frame_tick pulses the GOAL celebration lasts; range 1..255.
- `WIN_SCORE`, default 5: score that ends the game; range 1..15.

Ports:
- `clock`, in, 1: system clock.
- `resetn`, in, 1: reset, synchronous, active-low.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `start`, in, 1: level or pulse; requests a new game, honoured only in OVER.
- `ball_x`, in, 8: current ball x.
- `ball_y`, in, 7: current ball y.
- `resetGame`, out, 1: registered; high returns ball and players to start positions.
- `p1_score`, out, 4: player 1 goals.
- `p2_score`, out, 4: player 2 goals.
- `goal_flash`, out, 1: high during GOAL state.
- `last_scorer`, out, 1: 0 = player 1, 1 = player 2; valid after the first goal.
- `game_over`, out, 1: high in OVER.
- `winner`, out, 1: 0 = player 1, 1 = player 2; valid while game_over.

## Operation
- Combinational region decode:
  - `in_mouth` = (GOAL_Y_MIN <= ball_y <= GOAL_Y_MAX).
  - `in_right` = in_mouth && (ball_x + BALL_SIZE >= RIGHT_GOAL_X). Compute in 9 bits; no wrap.
  - `in_left` = in_mouth && (ball_x <= LEFT_GOAL_X).
  - `in_goal` = in_left || in_right.
- Scoring direction: player 1 attacks right, so in_right scores for p1. Player 2 attacks left, so in_left scores for p2. If both are true, in_right wins (unreachable with default geometry).
- States: ARM, PLAY, GOAL, KICKOFF, OVER.
- ARM: waits for the ball to leave the goal regions.
  - resetGame=0.
  - !in_goal → PLAY.
- PLAY: watches for a goal.
  - If in_goal: increment the scorer's score (saturate at 15), set last_scorer, clear hold_cnt, → GOAL.
  - Otherwise stay.
- GOAL: celebration hold.
  - goal_flash=1.
  - hold_cnt increments on each frame_tick.
  - On the frame_tick that makes hold_cnt == HOLD_FRAMES: if the scorer's score == WIN_SCORE → OVER (winner=scorer), else → KICKOFF.
  - Ball position changes are ignored, so there is no re-scoring.
- KICKOFF: resetGame=1 for exactly one cycle, then → ARM.
- OVER: holding state at end of game.
  - game_over=1 and resetGame=1 held continuously, keeping the ball frozen at start.
  - start=1 → clear both scores and winner, → KICKOFF.
- `start` outside OVER has no effect.

## Timing
- All outputs are registered and decoded from state/score registers; none are combinational from inputs.
- Reset (resetn=0 at a posedge), effective the next cycle:
  - state=ARM.
  - p1_score=p2_score=0.
  - hold_cnt=0.
  - resetGame=0, goal_flash=0, game_over=0, winner=0, last_scorer=0.
  - Reset overrides everything, including mid-GOAL and mid-OVER.
- Goal latency: ball inputs satisfying in_goal at edge N while in PLAY → score updated and goal_flash=1 after edge N.
- GOAL duration: exactly HOLD_FRAMES frame_tick pulses. A frame_tick coinciding with the PLAY→GOAL edge is not counted.
- resetGame asserts one cycle after GOAL exit and stays high for 1 cycle (KICKOFF). ARM then holds PLAY off until the ball feedback reflects the start position; this takes at least 1 cycle.
- OVER→KICKOFF: scores read 0 on the same cycle resetGame is high.

## Test plan
- Reset, then ball (80,60): ARM→PLAY next cycle; all outputs 0.
- PLAY, ball (150,60): p1_score 0→1 next cycle; goal_flash=1 for 60 frame_ticks. Then resetGame high exactly 1 cycle, then ARM. Ball held at (150,60) keeps state in ARM with no second increment. Ball (80,60) → PLAY.
- Ball (8,69) → p2_score=1, last_scorer=1. Ball (8,71) or (150,49) → no score.
- Drive p1 to 5 goals: after the 5th hold → game_over=1, winner=0, resetGame held high. start=1 → scores 0, one KICKOFF cycle, then ARM.
- resetn=0 mid-GOAL (hold_cnt=30): next cycle all outputs 0 and state ARM. Scores stay 0 with the ball at center.
- HOLD_FRAMES=1, frame_tick on the same cycle as goal entry: celebration ends on the next frame_tick, not the coincident one.

Source files
------------

// File: rtl/goal_scorekeeper.sv
// Goal detection, score keeping and kick-off control for the pong-style soccer game.
// Watches registered ball position, runs the goal/celebration/game-over FSM and drives resetGame.
module goal_scorekeeper #(
  parameter int unsigned LEFT_GOAL_X  = 8,
  parameter int unsigned RIGHT_GOAL_X = 152,
  parameter int unsigned GOAL_Y_MIN   = 50,
  parameter int unsigned GOAL_Y_MAX   = 70,
  parameter int unsigned BALL_SIZE    = 2,
  parameter int unsigned HOLD_FRAMES  = 60,
  parameter int unsigned WIN_SCORE    = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  output logic       resetGame,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       goal_flash,
  output logic       last_scorer,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned SW = 4;
  localparam int unsigned HW = 8;

  typedef enum logic [2:0] {ARM, PLAY, GOAL, KICKOFF, OVER} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   p1_q, p1_d, p2_q, p2_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            last_q, last_d, win_q, win_d;
  logic            rg_q, rg_d, flash_q, flash_d, over_q, over_d;

  logic            in_mouth_c, in_left_c, in_right_c, in_goal_c;

  // Goal region decode; right edge sum kept one bit wider so x near 255 cannot wrap
  always_comb begin
    in_mouth_c = (ball_y >= YW'(GOAL_Y_MIN)) && (ball_y <= YW'(GOAL_Y_MAX));
    in_right_c = in_mouth_c &&
                 (({1'b0, ball_x} + (XW+1)'(BALL_SIZE)) >= (XW+1)'(RIGHT_GOAL_X));
    in_left_c  = in_mouth_c && (ball_x <= XW'(LEFT_GOAL_X));
    in_goal_c  = in_left_c || in_right_c;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ARM;
      p1_q    <= '0;
      p2_q    <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      win_q   <= 1'b0;
      rg_q    <= 1'b0;
      flash_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      win_q   <= win_d;
      rg_q    <= rg_d;
      flash_q <= flash_d;
      over_q  <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    hold_d  = hold_q;
    last_d  = last_q;
    win_d   = win_q;
    unique case (state_q)
      ARM: begin
        if (!in_goal_c) state_d = PLAY;
      end
      PLAY: begin
        if (in_goal_c) begin
          hold_d  = '0;
          state_d = GOAL;
          // Right goal takes priority if both regions ever overlap
          if (in_right_c) begin
            p1_d   = (p1_q == {SW{1'b1}}) ? p1_q : p1_q + SW'(1);
            last_d = 1'b0;
          end else begin
            p2_d   = (p2_q == {SW{1'b1}}) ? p2_q : p2_q + SW'(1);
            last_d = 1'b1;
          end
        end
      end
      GOAL: begin
        if (frame_tick) begin
          hold_d = hold_q + HW'(1);
          if (hold_d == HW'(HOLD_FRAMES)) begin
            if ((last_q ? p2_q : p1_q) == SW'(WIN_SCORE)) begin
              state_d = OVER;
              win_d   = last_q;
            end else begin
              state_d = KICKOFF;
            end
          end
        end
      end
      KICKOFF: begin
        state_d = ARM;
      end
      OVER: begin
        if (start) begin
          p1_d    = '0;
          p2_d    = '0;
          win_d   = 1'b0;
          state_d = KICKOFF;
        end
      end
      default: state_d = ARM;
    endcase
    // Status outputs registered from the next state so they align with it
    rg_d    = (state_d == KICKOFF) || (state_d == OVER);
    flash_d = (state_d == GOAL);
    over_d  = (state_d == OVER);
  end

  assign resetGame   = rg_q;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign goal_flash  = flash_q;
  assign last_scorer = last_q;
  assign game_over   = over_q;
  assign winner      = win_q;

endmodule

// File: tb/tb_goal_scorekeeper.sv
// Scoreboard bench for goal_scorekeeper: expected outputs queued per driven cycle, compared per test.
module tb_goal_scorekeeper;

  localparam int HOLD = 60;

  typedef struct packed {
    logic       rg;
    logic [3:0] p1;
    logic [3:0] p2;
    logic       flash;
    logic       last;
    logic       over;
    logic       win;
  } outs_t;

  typedef struct {
    outs_t v;
    string tag;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ball_x = 8'd80;
  logic [6:0] ball_y = 7'd60;

  logic       rg, flash, last, over, win;
  logic [3:0] p1, p2;
  logic       rg1, flash1, last1, over1, win1;
  logic [3:0] p1_1, p2_1;

  exp_t  exp_q[$];
  outs_t obs_q[$];
  int    checks = 0;
  int    passed = 0;

  logic       e_rg = 0, e_flash = 0, e_last = 0, e_over = 0, e_win = 0;
  logic [3:0] e_p1 = 0, e_p2 = 0;

  always #5 clock = ~clock;

  goal_scorekeeper dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .resetGame(rg), .p1_score(p1), .p2_score(p2),
    .goal_flash(flash), .last_scorer(last), .game_over(over), .winner(win)
  );

  goal_scorekeeper #(.HOLD_FRAMES(1)) dut1 (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .resetGame(rg1), .p1_score(p1_1), .p2_score(p2_1),
    .goal_flash(flash1), .last_scorer(last1), .game_over(over1), .winner(win1)
  );

  function automatic outs_t mk(input logic r, input logic [3:0] a, input logic [3:0] b,
                               input logic f, input logic l, input logic g, input logic w);
    outs_t o;
    o.rg = r; o.p1 = a; o.p2 = b; o.flash = f; o.last = l; o.over = g; o.win = w;
    return o;
  endfunction

  function automatic outs_t cur();
    return mk(e_rg, e_p1, e_p2, e_flash, e_last, e_over, e_win);
  endfunction

  // Drive one cycle, queue the expected outputs after the edge, capture the DUT's outputs
  task automatic cyc(input logic rn, input logic ft, input logic st,
                     input logic [7:0] x, input logic [6:0] y, input string tag);
    exp_t e;
    resetn = rn; frame_tick = ft; start = st; ball_x = x; ball_y = y;
    e.v = cur(); e.tag = tag;
    exp_q.push_back(e);
    @(posedge clock); #1;
    obs_q.push_back(mk(rg, p1, p2, flash, last, over, win));
  endtask

  task automatic clear_model();
    e_rg = 0; e_flash = 0; e_last = 0; e_over = 0; e_win = 0; e_p1 = 0; e_p2 = 0;
  endtask

  // One goal from PLAY through its celebration; ends in PLAY unless the game is won
  task automatic do_goal(input logic p2side, input logic [7:0] gx, input logic [6:0] gy,
                         input logic coincide_ft);
    if (p2side) begin e_p2 = e_p2 + 4'd1; e_last = 1'b1; end
    else        begin e_p1 = e_p1 + 4'd1; e_last = 1'b0; end
    e_flash = 1'b1;
    cyc(1, coincide_ft, 0, gx, gy, "goal_entry");
    for (int k = 1; k <= HOLD; k++) begin
      if (k % 10 == 0) cyc(1, 0, 0, gx, gy, "hold_gap");
      if (k == HOLD) begin
        e_flash = 1'b0; e_rg = 1'b1;
        if ((e_last ? e_p2 : e_p1) == 4'd5) begin e_over = 1'b1; e_win = e_last; end
      end
      cyc(1, 1, 0, gx, gy, "hold_tick");
    end
    if (!e_over) begin
      e_rg = 1'b0;
      cyc(1, 0, 0, gx, gy, "kickoff_end");
      cyc(1, 1, 0, gx, gy, "arm_in_goal");
      cyc(1, 0, 0, gx, gy, "arm_in_goal2");
      cyc(1, 0, 0, 8'd80, 7'd60, "arm_to_play");
    end
  endtask

  task automatic test_reset();
    exp_t e; outs_t o;
    clear_model();
    cyc(0, 0, 0, 8'd80, 7'd60, "reset");
    cyc(1, 0, 0, 8'd80, 7'd60, "arm_to_play");
    cyc(1, 1, 0, 8'd80, 7'd60, "play_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) $display("FAIL reset/%s: got %h expected %h", e.tag, o, e.v);
      else passed++;
    end
  endtask

  task automatic test_p1_goal();
    exp_t e; outs_t o;
    do_goal(1'b0, 8'd150, 7'd60, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) $display("FAIL p1_goal/%s: got %h expected %h", e.tag, o, e.v);
      else passed++;
    end
  endtask

  task automatic test_p2_goal();
    exp_t e; outs_t o;
    do_goal(1'b1, 8'd8, 7'd69, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) $display("FAIL p2_goal/%s: got %h expected %h", e.tag, o, e.v);
      else passed++;
    end
  endtask

  task automatic test_no_score();
    exp_t e; outs_t o;
    cyc(1, 0, 0, 8'd8,   7'd71, "left_above_mouth");
    cyc(1, 0, 0, 8'd150, 7'd49, "right_below_mouth");
    cyc(1, 1, 0, 8'd9,   7'd60, "left_one_past_line");
    cyc(1, 0, 0, 8'd149, 7'd60, "right_one_short");
    cyc(1, 0, 1, 8'd80,  7'd60, "start_in_play");
    cyc(1, 0, 0, 8'd0,   7'd127, "corner");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) $display("FAIL no_score/%s: got %h expected %h", e.tag, o, e.v);
      else passed++;
    end
  endtask

  task automatic test_win();
    exp_t e; outs_t o;
    do_goal(1'b0, 8'd150, 7'd50, 1'b0);
    do_goal(1'b0, 8'd255, 7'd70, 1'b0);
    do_goal(1'b0, 8'd150, 7'd60, 1'b0);
    do_goal(1'b0, 8'd200, 7'd55, 1'b0);
    cyc(1, 0, 0, 8'd80, 7'd60, "over_hold");
    cyc(1, 1, 0, 8'd150, 7'd60, "over_hold_goal_pos");
    cyc(1, 0, 0, 8'd80, 7'd60, "over_hold2");
    e_p1 = 0; e_p2 = 0; e_over = 0; e_win = 0;
    cyc(1, 0, 1, 8'd80, 7'd60, "start_kickoff");
    e_rg = 0;
    cyc(1, 0, 1, 8'd80, 7'd60, "kickoff_to_arm");
    cyc(1, 0, 0, 8'd80, 7'd60, "arm_to_play");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) $display("FAIL win/%s: got %h expected %h", e.tag, o, e.v);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_goal();
    exp_t e; outs_t o;
    e_p1 = e_p1 + 4'd1; e_last = 1'b0; e_flash = 1'b1;
    cyc(1, 0, 0, 8'd150, 7'd60, "goal_entry");
    for (int k = 0; k < 30; k++) cyc(1, 1, 0, 8'd150, 7'd60, "hold_tick");
    clear_model();
    cyc(0, 1, 0, 8'd80, 7'd60, "reset_mid_goal");
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 8'd80, 7'd60, "center_after_reset");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) $display("FAIL reset_mid_goal/%s: got %h expected %h", e.tag, o, e.v);
      else passed++;
    end
  endtask

  // Second instance has HOLD_FRAMES=1: the tick coincident with goal entry must not count
  task automatic test_hold1();
    exp_t e; outs_t o, o1, x1;
    clear_model();
    cyc(0, 0, 0, 8'd80, 7'd60, "reset");
    cyc(1, 0, 0, 8'd80, 7'd60, "arm_to_play");
    e_p1 = 4'd1; e_flash = 1'b1;
    cyc(1, 1, 0, 8'd150, 7'd60, "goal_entry_tick");
    o1 = mk(rg1, p1_1, p2_1, flash1, last1, over1, win1);
    x1 = mk(0, 4'd1, 4'd0, 1, 0, 0, 0);
    checks++;
    if (o1 !== x1) $display("FAIL hold1/entry: got %h expected %h", o1, x1); else passed++;
    cyc(1, 0, 0, 8'd150, 7'd60, "hold_no_tick");
    o1 = mk(rg1, p1_1, p2_1, flash1, last1, over1, win1);
    checks++;
    if (o1 !== x1) $display("FAIL hold1/no_tick: got %h expected %h", o1, x1); else passed++;
    cyc(1, 1, 0, 8'd150, 7'd60, "hold_tick");
    o1 = mk(rg1, p1_1, p2_1, flash1, last1, over1, win1);
    x1 = mk(1, 4'd1, 4'd0, 0, 0, 0, 0);
    checks++;
    if (o1 !== x1) $display("FAIL hold1/exit: got %h expected %h", o1, x1); else passed++;
    cyc(1, 0, 0, 8'd150, 7'd60, "after_kickoff");
    o1 = mk(rg1, p1_1, p2_1, flash1, last1, over1, win1);
    x1 = mk(0, 4'd1, 4'd0, 0, 0, 0, 0);
    checks++;
    if (o1 !== x1) $display("FAIL hold1/arm: got %h expected %h", o1, x1); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) $display("FAIL hold1_main/%s: got %h expected %h", e.tag, o, e.v);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_p1_goal();
    test_p2_goal();
    test_no_score();
    test_win();
    test_reset_mid_goal();
    test_hold1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
